seg_scan_driver: RTL and testbench

Time-multiplexing scanner between the eight-digit display composer and the board's physical seven-segment bus. Consumes the 64-bit parallel segment image and per-digit enable vector, snapshots it once per frame, and drives one digit at a time through shared active-low segment lines and active-low anode selects. It is the only block allowed to touch the display pins.

---
 rtl/seg_scan_driver.sv | 80 ++++++++
 tb/tb_seg_scan_driver.sv | 137 +++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed eight-digit seven-segment scanner with per-frame snapshot and active-low pins.
// Optional per-slot dead time is enabled by defining SEG_SCAN_BLANK_EN.
module seg_scan_driver #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] seg_out,
  input  logic [7:0]  seg_en,
  output logic [7:0]  seg,
  output logic [7:0]  an,
  output logic        frame_start
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [63:0]      img;
  logic [7:0]       en;
  logic             primed;
  logic             blank;
  logic [7:0]       seg_nxt;
  logic [7:0]       an_nxt;

`ifdef SEG_SCAN_BLANK_EN
  assign blank = (cnt < CNT_W'(BLANK_CYC));
`else
  // Dead time is disabled in this build; the parameter is kept only for a uniform interface.
  logic unused_blank_cfg;
  assign unused_blank_cfg = (BLANK_CYC < SCAN_DIV);
  assign blank = 1'b0;
`endif

  always_comb begin
    seg_nxt = 8'hff;
    an_nxt  = 8'hff;
    if (primed && en[idx] && !blank) begin
      an_nxt  = ~(8'h01 << idx);
      seg_nxt = ~img[{idx, 3'b000} +: 8];
    end
  end

  // Disabled digits still consume their slot so brightness does not depend on the enable pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= '0;
      img         <= '0;
      en          <= '0;
      primed      <= 1'b0;
      frame_start <= 1'b0;
      seg         <= 8'hff;
      an          <= 8'hff;
    end else begin
      frame_start <= 1'b0;
      seg         <= seg_nxt;
      an          <= an_nxt;
      if (!primed) begin
        img         <= seg_out;
        en          <= seg_en;
        primed      <= 1'b1;
        frame_start <= 1'b1;
      end else if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 3'd1;
        if (idx == 3'd7) begin
          img         <= seg_out;
          en          <= seg_en;
          frame_start <= 1'b1;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: a cycle-count model pushes expected pin values,
// which are popped and compared after each clock edge.
module tb_seg_scan_driver;

  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 1;
  localparam int FRAME     = 8 * SCAN_DIV;
`ifdef SEG_SCAN_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] seg_out;
  logic [7:0]  seg_en;
  logic [7:0]  seg;
  logic [7:0]  an;
  logic        frame_start;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] seg;
    logic       fs;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] m_img;
  logic [7:0]  m_en;
  int          k;
  int          n_checks = 0;
  int          n_pass   = 0;

  seg_scan_driver #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_out    (seg_out),
    .seg_en     (seg_en),
    .seg        (seg),
    .an         (an),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: got %h expected %h (k=%0d)", tag, obs, exp, k);
  endtask

  // Edge k after reset release: edge 1 primes, then digit d occupies edges 2+4d .. 5+4d of each frame.
  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      exp_t e;
      exp_t got;
      int   d;
      int   p;
      logic lit;
      k++;
      if (k == 1) begin
        e = '{an: 8'hff, seg: 8'hff, fs: 1'b1};
        m_img = seg_out;
        m_en  = seg_en;
      end else begin
        d = ((k - 2) / SCAN_DIV) % 8;
        p = (k - 2) % SCAN_DIV;
        lit = m_en[d] && !(BLANK_ON && (p < BLANK_CYC));
        e.an  = lit ? ~(8'h01 << d) : 8'hff;
        e.seg = lit ? ~m_img[8*d +: 8] : 8'hff;
        e.fs  = ((k - 1) % FRAME) == 0;
        if (e.fs) begin
          m_img = seg_out;
          m_en  = seg_en;
        end
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      checkOutput("an", an, got.an);
      checkOutput("seg", seg, got.seg);
      checkOutput("frame_start", {7'b0, frame_start}, {7'b0, got.fs});
      checkOutput("an_onehot", 8'($countones(~an) <= 1), 8'd1);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    seg_out = 64'h0102040810204080;
    seg_en  = 8'hff;
    k       = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset values");
    checkOutput("rst_an", an, 8'hff);
    checkOutput("rst_seg", seg, 8'hff);
    checkOutput("rst_fs", {7'b0, frame_start}, 8'h00);

    $display("[TB] priming and full scan");
    rst_n = 1'b1;
    applyStimulus(46);

    $display("[TB] mid-frame input change during digit 3");
    seg_out[15:8]  = 8'h3c;
    seg_out[63:56] = 8'h5a;
    applyStimulus(34);

    $display("[TB] disabled digit 4");
    seg_en = 8'b1110_1111;
    applyStimulus(71);

    $display("[TB] mid-frame reset during digit 5");
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_an", an, 8'hff);
    checkOutput("async_rst_seg", seg, 8'hff);
    checkOutput("async_rst_fs", {7'b0, frame_start}, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("hold_rst_an", an, 8'hff);
    checkOutput("hold_rst_seg", seg, 8'hff);
    seg_out = 64'hf1e2d3c4b5a69788;
    seg_en  = 8'hff;
    k       = 0;
    rst_n   = 1'b1;
    applyStimulus(40);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
